// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: latch control codes and controller states.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE,
    PIPE_STALL,
    PIPE_NOP
  } pipe_state_t;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT,
    HALTED
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 32,
  parameter int FSEL_W  = $clog2(NUM_FWD + 1)
);

  logic                           ihit;
  logic                           dhit;
  logic                           m_memreq;
  logic                           redirect;
  logic                           w_halt;
  logic [REG_W-1:0]               d_rs;
  logic [REG_W-1:0]               d_rt;
  logic                           d_use_rs;
  logic                           d_use_rt;
  logic [REG_W-1:0]               e_wsel;
  logic                           e_wen;
  logic                           e_load;
  logic [REG_W-1:0]               e_rs;
  logic [REG_W-1:0]               e_rt;
  logic [NUM_FWD-1:0][REG_W-1:0]  fwd_wsel;
  logic [NUM_FWD-1:0]             fwd_wen;

  pipe_state_t                    fd_state;
  pipe_state_t                    de_state;
  pipe_state_t                    em_state;
  pipe_state_t                    mw_state;
  logic                           pc_wen;
  logic [FSEL_W-1:0]              fsel_a;
  logic [FSEL_W-1:0]              fsel_b;
  logic [CNT_W-1:0]               stall_cnt;
  logic [CNT_W-1:0]               flush_cnt;
  logic                           halted;

  modport master (
    output ihit, dhit, m_memreq, redirect, w_halt,
           d_rs, d_rt, d_use_rs, d_use_rt,
           e_wsel, e_wen, e_load, e_rs, e_rt,
           fwd_wsel, fwd_wen,
    input  fd_state, de_state, em_state, mw_state, pc_wen,
           fsel_a, fsel_b, stall_cnt, flush_cnt, halted
  );

  modport slave (
    input  ihit, dhit, m_memreq, redirect, w_halt,
           d_rs, d_rt, d_use_rs, d_use_rt,
           e_wsel, e_wen, e_load, e_rs, e_rt,
           fwd_wsel, fwd_wen,
    output fd_state, de_state, em_state, mw_state, pc_wen,
           fsel_a, fsel_b, stall_cnt, flush_cnt, halted
  );

endinterface

// File: rtl/fwd_select.sv
// Priority encoder choosing the youngest forwarding source that writes src_reg.
module fwd_select #(
  parameter int NUM_FWD = 3,
  parameter int REG_W   = 5,
  parameter int FSEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_W-1:0]              src_reg,
  input  logic [NUM_FWD-1:0][REG_W-1:0] fwd_wsel,
  input  logic [NUM_FWD-1:0]            fwd_wen,
  output logic [FSEL_W-1:0]             fsel
);

  logic [NUM_FWD-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
      assign match[gi] = fwd_wen[gi] && (fwd_wsel[gi] == src_reg) && (src_reg != '0);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching index ends up selected.
  always_comb begin
    fsel = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (match[i]) fsel = FSEL_W'(i + 1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: latch control, PC enable, operand forwarding and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int NUM_FWD  = 3,
  parameter int FSEL_W   = $clog2(NUM_FWD + 1),
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_ctrl_if.slave hz
);

  localparam int LU_W = $clog2(LOAD_LAT + 1);

  hazard_state_t     state_reg, state_next;
  logic [LU_W-1:0]   lu_cnt_reg, lu_cnt_next;
  logic              redirect_pend_reg, redirect_pend_next;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;

  pipe_state_t       fd_c, de_c, em_c, mw_c;
  logic              pc_wen_c;
  logic              flush_c;
  logic [FSEL_W-1:0] fsel_a_c, fsel_b_c;

  logic lu_hazard, mem_miss, redir_any, blocked;

  assign lu_hazard = hz.e_load && hz.e_wen && (hz.e_wsel != '0) &&
                     ((hz.d_use_rs && (hz.d_rs == hz.e_wsel)) ||
                      (hz.d_use_rt && (hz.d_rt == hz.e_wsel)));
  assign mem_miss  = hz.m_memreq && !hz.dhit;
  assign redir_any = hz.redirect || redirect_pend_reg;
  // Halt, a D-side miss and an I-side miss all freeze the whole pipe.
  assign blocked   = hz.w_halt || mem_miss || !hz.ihit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg         <= RUN;
      lu_cnt_reg        <= '0;
      redirect_pend_reg <= 1'b0;
      stall_cnt_reg     <= '0;
      flush_cnt_reg     <= '0;
    end else begin
      state_reg         <= state_next;
      lu_cnt_reg        <= lu_cnt_next;
      redirect_pend_reg <= redirect_pend_next;
      if (!pc_wen_c && (state_reg != HALTED) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_c && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next         = state_reg;
    lu_cnt_next        = lu_cnt_reg;
    redirect_pend_next = redirect_pend_reg;
    case (state_reg)
      RUN, LU_STALL: begin
        if (hz.w_halt) begin
          state_next = HALTED;
        end else if (mem_miss) begin
          state_next = MEM_WAIT;
        end else if (!hz.ihit) begin
          if (hz.redirect) redirect_pend_next = 1'b1;
        end else if (redir_any) begin
          redirect_pend_next = 1'b0;
          lu_cnt_next        = '0;
          state_next         = RUN;
        end else if (state_reg == LU_STALL) begin
          lu_cnt_next = lu_cnt_reg - LU_W'(1);
          if (lu_cnt_reg == LU_W'(1)) state_next = RUN;
        end else if (lu_hazard && (LOAD_LAT > 1)) begin
          lu_cnt_next = LU_W'(LOAD_LAT - 1);
          state_next  = LU_STALL;
        end
      end
      MEM_WAIT: begin
        if (hz.redirect) redirect_pend_next = 1'b1;
        // Remaining load-use bubbles are resumed after the data access completes.
        if (hz.dhit) state_next = (lu_cnt_reg != '0) ? LU_STALL : RUN;
      end
      default: state_next = state_reg;
    endcase
  end

  always_comb begin
    fd_c     = PIPE_STALL;
    de_c     = PIPE_STALL;
    em_c     = PIPE_STALL;
    mw_c     = PIPE_STALL;
    pc_wen_c = 1'b0;
    flush_c  = 1'b0;
    if (!RST) begin
      case (state_reg)
        RUN, LU_STALL: begin
          if (blocked) begin
            pc_wen_c = 1'b0;
          end else if (redir_any) begin
            fd_c     = PIPE_NOP;
            de_c     = PIPE_NOP;
            em_c     = PIPE_NOP;
            mw_c     = PIPE_ENABLE;
            pc_wen_c = 1'b1;
            flush_c  = 1'b1;
          end else if (lu_hazard || (state_reg == LU_STALL)) begin
            de_c = PIPE_NOP;
            em_c = PIPE_ENABLE;
            mw_c = PIPE_ENABLE;
          end else begin
            fd_c     = PIPE_ENABLE;
            de_c     = PIPE_ENABLE;
            em_c     = PIPE_ENABLE;
            mw_c     = PIPE_ENABLE;
            pc_wen_c = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (hz.dhit) begin
            fd_c     = hz.ihit ? PIPE_ENABLE : PIPE_NOP;
            de_c     = PIPE_ENABLE;
            em_c     = PIPE_ENABLE;
            mw_c     = PIPE_ENABLE;
            pc_wen_c = hz.ihit;
          end
        end
        default: pc_wen_c = 1'b0;
      endcase
    end
  end

  fwd_select #(.NUM_FWD(NUM_FWD), .REG_W(REG_W), .FSEL_W(FSEL_W)) u_fwd_a (
    .src_reg  (hz.e_rs),
    .fwd_wsel (hz.fwd_wsel),
    .fwd_wen  (hz.fwd_wen),
    .fsel     (fsel_a_c)
  );

  fwd_select #(.NUM_FWD(NUM_FWD), .REG_W(REG_W), .FSEL_W(FSEL_W)) u_fwd_b (
    .src_reg  (hz.e_rt),
    .fwd_wsel (hz.fwd_wsel),
    .fwd_wen  (hz.fwd_wen),
    .fsel     (fsel_b_c)
  );

  assign hz.fd_state  = fd_c;
  assign hz.de_state  = de_c;
  assign hz.em_state  = em_c;
  assign hz.mw_state  = mw_c;
  assign hz.pc_wen    = pc_wen_c;
  assign hz.fsel_a    = RST ? '0 : fsel_a_c;
  assign hz.fsel_b    = RST ? '0 : fsel_b_c;
  assign hz.stall_cnt = stall_cnt_reg;
  assign hz.flush_cnt = flush_cnt_reg;
  assign hz.halted    = (state_reg == HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LAT=1 with 2-bit counters, LOAD_LAT=3 with 32-bit).
`define DRV(sig) assign if_a.sig = sig; assign if_b.sig = sig;

module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam pipe_state_t E = PIPE_ENABLE;
  localparam pipe_state_t S = PIPE_STALL;
  localparam pipe_state_t N = PIPE_NOP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, ihit, dhit, m_memreq, redirect, w_halt;
  logic            d_use_rs, d_use_rt, e_wen, e_load;
  logic [4:0]      d_rs, d_rt, e_wsel, e_rs, e_rt;
  logic [2:0][4:0] fwd_wsel;
  logic [2:0]      fwd_wen;

  hazard_ctrl_if #(.REG_W(5), .NUM_FWD(3), .CNT_W(2))  if_a ();
  hazard_ctrl_if #(.REG_W(5), .NUM_FWD(3), .CNT_W(32)) if_b ();

  `DRV(ihit) `DRV(dhit) `DRV(m_memreq) `DRV(redirect) `DRV(w_halt)
  `DRV(d_rs) `DRV(d_rt) `DRV(d_use_rs) `DRV(d_use_rt)
  `DRV(e_wsel) `DRV(e_wen) `DRV(e_load) `DRV(e_rs) `DRV(e_rt)
  `DRV(fwd_wsel) `DRV(fwd_wen)

  hazard_ctrl #(.REG_W(5), .NUM_FWD(3), .LOAD_LAT(1), .CNT_W(2)) dut_a (
    .CLK (clk),
    .RST (rst),
    .hz  (if_a)
  );

  hazard_ctrl #(.REG_W(5), .NUM_FWD(3), .LOAD_LAT(3), .CNT_W(32)) dut_b (
    .CLK (clk),
    .RST (rst),
    .hz  (if_b)
  );

  typedef struct {
    string       nm;
    int          which;
    pipe_state_t fd, de, em, mw;
    logic        pcw;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
    logic        h;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    pipe_state_t fd, de, em, mw;
    logic        pcw, h;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.which == 0) begin
        fd = if_a.fd_state; de = if_a.de_state; em = if_a.em_state; mw = if_a.mw_state;
        pcw = if_a.pc_wen; fa = if_a.fsel_a; fb = if_a.fsel_b;
        sc = 32'(if_a.stall_cnt); fc = 32'(if_a.flush_cnt); h = if_a.halted;
      end else begin
        fd = if_b.fd_state; de = if_b.de_state; em = if_b.em_state; mw = if_b.mw_state;
        pcw = if_b.pc_wen; fa = if_b.fsel_a; fb = if_b.fsel_b;
        sc = if_b.stall_cnt; fc = if_b.flush_cnt; h = if_b.halted;
      end
      checks++;
      if ({fd, de, em, mw, pcw, fa, fb, sc, fc, h} !==
          {e.fd, e.de, e.em, e.mw, e.pcw, e.fa, e.fb, e.sc, e.fc, e.h}) begin
        errors++;
        $display("FAIL %s: got fd/de/em/mw=%0d/%0d/%0d/%0d pc_wen=%0b fsel=%0d/%0d stall=%0d flush=%0d halted=%0b; want %0d/%0d/%0d/%0d pc_wen=%0b fsel=%0d/%0d stall=%0d flush=%0d halted=%0b",
                 e.nm, fd, de, em, mw, pcw, fa, fb, sc, fc, h,
                 e.fd, e.de, e.em, e.mw, e.pcw, e.fa, e.fb, e.sc, e.fc, e.h);
      end else begin
        $display("ok   %s (dut %0d) stall=%0d flush=%0d", e.nm, e.which, sc, fc);
      end
    end
  end

  task automatic cyc(input string nm, input int which,
                     input pipe_state_t fd, input pipe_state_t de,
                     input pipe_state_t em, input pipe_state_t mw,
                     input logic pcw, input int fa, input int fb,
                     input int sc, input int fc, input logic h);
    exp_t e;
    e.nm = nm; e.which = which;
    e.fd = fd; e.de = de; e.em = em; e.mw = mw;
    e.pcw = pcw; e.fa = 2'(fa); e.fb = 2'(fb);
    e.sc = 32'(sc); e.fc = 32'(fc); e.h = h;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; m_memreq = 1'b0; redirect = 1'b0; w_halt = 1'b0;
    d_rs = '0; d_rt = '0; d_use_rs = 1'b0; d_use_rt = 1'b0;
    e_wsel = '0; e_wen = 1'b0; e_load = 1'b0; e_rs = '0; e_rt = '0;
    fwd_wsel = '0; fwd_wen = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_use_rs(input logic [4:0] r);
    e_load = 1'b1; e_wen = 1'b1; e_wsel = r; d_rs = r; d_use_rs = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // Matching forwarding inputs must still read 0 while reset is held.
    fwd_wen = 3'b001; fwd_wsel[0] = 5'd5; e_rs = 5'd5; e_rt = 5'd5;
    cyc("reset_a", 0, S, S, S, S, 0, 0, 0, 0, 0, 0);
    cyc("reset_b", 1, S, S, S, S, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle();

    // LOAD_LAT=1 controller, 2-bit counters
    load_use_rs(5'd8);
    cyc("lu1_bubble", 0, S, N, E, E, 0, 0, 0, 0, 0, 0);
    idle();
    cyc("lu1_resume", 0, E, E, E, E, 1, 0, 0, 1, 0, 0);
    load_use_rs(5'd0);
    cyc("lu_reg0", 0, E, E, E, E, 1, 0, 0, 1, 0, 0);
    idle();
    e_load = 1'b1; e_wen = 1'b1; e_wsel = 5'd9; d_rt = 5'd9; d_use_rt = 1'b1;
    cyc("lu1_rt", 0, S, N, E, E, 0, 0, 0, 1, 0, 0);
    d_use_rt = 1'b0;
    cyc("lu_no_use", 0, E, E, E, E, 1, 0, 0, 2, 0, 0);
    d_use_rt = 1'b1;
    cyc("stall_sat1", 0, S, N, E, E, 0, 0, 0, 2, 0, 0);
    cyc("stall_sat2", 0, S, N, E, E, 0, 0, 0, 3, 0, 0);
    idle();
    cyc("stall_sat3", 0, E, E, E, E, 1, 0, 0, 3, 0, 0);
    redirect = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc("flush_step", 0, N, N, N, E, 1, 0, 0, 3, (i > 3) ? 3 : i, 0);
    idle();
    cyc("flush_sat", 0, E, E, E, E, 1, 0, 0, 3, 3, 0);

    // LOAD_LAT=3 controller with a data miss in the middle of the bubbles
    do_reset();
    load_use_rs(5'd8);
    cyc("lu3_b1", 1, S, N, E, E, 0, 0, 0, 0, 0, 0);
    idle();
    cyc("lu3_b2", 1, S, N, E, E, 0, 0, 0, 1, 0, 0);
    m_memreq = 1'b1; dhit = 1'b0;
    cyc("lu3_memmiss", 1, S, S, S, S, 0, 0, 0, 2, 0, 0);
    cyc("lu3_memwait", 1, S, S, S, S, 0, 0, 0, 3, 0, 0);
    dhit = 1'b1;
    cyc("lu3_memdone", 1, E, E, E, E, 1, 0, 0, 4, 0, 0);
    idle();
    cyc("lu3_b3", 1, S, N, E, E, 0, 0, 0, 4, 0, 0);
    cyc("lu3_done", 1, E, E, E, E, 1, 0, 0, 5, 0, 0);
    m_memreq = 1'b1; dhit = 1'b0;
    cyc("mw_enter", 1, S, S, S, S, 0, 0, 0, 5, 0, 0);
    dhit = 1'b1; ihit = 1'b0;
    cyc("mw_no_ihit", 1, N, E, E, E, 0, 0, 0, 6, 0, 0);
    idle();
    cyc("mw_after", 1, E, E, E, E, 1, 0, 0, 7, 0, 0);

    // Redirect held pending across an I-cache miss
    redirect = 1'b1; ihit = 1'b0;
    cyc("redir_miss", 1, S, S, S, S, 0, 0, 0, 7, 0, 0);
    redirect = 1'b0;
    cyc("redir_wait", 1, S, S, S, S, 0, 0, 0, 8, 0, 0);
    ihit = 1'b1;
    cyc("redir_flush", 1, N, N, N, E, 1, 0, 0, 9, 0, 0);
    cyc("redir_clear", 1, E, E, E, E, 1, 0, 0, 9, 1, 0);

    // Forwarding priority and register 0
    fwd_wsel[0] = 5'd5; fwd_wsel[1] = 5'd5; fwd_wsel[2] = 5'd7; fwd_wen = 3'b111;
    e_rs = 5'd5; e_rt = 5'd7;
    cyc("fwd_prio", 1, E, E, E, E, 1, 1, 3, 9, 1, 0);
    e_rs = 5'd0; fwd_wsel[0] = 5'd0;
    cyc("fwd_reg0", 1, E, E, E, E, 1, 0, 3, 9, 1, 0);
    e_rs = 5'd5; fwd_wsel[0] = 5'd5; fwd_wen = 3'b110; e_rt = 5'd6;
    cyc("fwd_wen", 1, E, E, E, E, 1, 2, 0, 9, 1, 0);
    idle();

    // Halt beats redirect, is sticky, and only reset clears it
    w_halt = 1'b1; redirect = 1'b1;
    cyc("halt_req", 1, S, S, S, S, 0, 0, 0, 9, 1, 0);
    w_halt = 1'b0;
    cyc("halt_sticky1", 1, S, S, S, S, 0, 0, 0, 10, 1, 1);
    idle();
    cyc("halt_sticky2", 1, S, S, S, S, 0, 0, 0, 10, 1, 1);
    rst = 1'b1;
    cyc("halt_in_reset", 1, S, S, S, S, 0, 0, 0, 10, 1, 1);
    rst = 1'b0;
    cyc("post_reset", 1, E, E, E, E, 1, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
